// File: rtl/io_manager.sv
// Memory-mapped I/O decoder between the CPU data port, a word RAM and a UART.
// Device paths are combinational; only the sticky fault status is registered.
module io_manager (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  cpu_mode,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic [1:0]  ram_mode,
    output logic [20:0] ram_addr,
    output logic [3:0]  ram_be,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata,
    output logic [1:0]  serial_mode,
    output logic        serial_addr,
    output logic [31:0] serial_wdata,
    input  logic [31:0] serial_rdata,
    input  logic        fault_clr,
    output logic        fault,
    output logic [1:0]  fault_cause,
    output logic [31:0] fault_addr
);
    localparam logic [3:0] MODE_LW  = 4'b0001;
    localparam logic [3:0] MODE_LH  = 4'b0010;
    localparam logic [3:0] MODE_LHU = 4'b0011;
    localparam logic [3:0] MODE_LB  = 4'b0100;
    localparam logic [3:0] MODE_LBU = 4'b0101;
    localparam logic [3:0] MODE_SW  = 4'b1001;
    localparam logic [3:0] MODE_SH  = 4'b1010;
    localparam logic [3:0] MODE_SB  = 4'b1100;

    localparam logic [1:0] DEV_IDLE  = 2'b00;
    localparam logic [1:0] DEV_READ  = 2'b01;
    localparam logic [1:0] DEV_WRITE = 2'b10;

    localparam logic [1:0] CAUSE_UNMAPPED   = 2'b01;
    localparam logic [1:0] CAUSE_MISALIGNED = 2'b10;

    logic        w_is_read;
    logic        w_is_write;
    logic        w_misaligned;
    logic        w_ram_hit;
    logic        w_ser_hit;
    logic        w_fault;
    logic        w_ram_sel;
    logic        w_ser_sel;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_word;
    logic [31:0] w_lane;
    logic [31:0] w_rdata;

    logic        r_fault;
    logic [1:0]  r_fault_cause;
    logic [31:0] r_fault_addr;

    // Serial registers occupy one 8-byte window: 0xBFD003F8 data, 0xBFD003FC status.
    assign w_ram_hit = (cpu_addr[31:23] == 9'h100);
    assign w_ser_hit = (cpu_addr[31:3] == 29'h17FA007F);

    always_comb begin
        w_is_read    = 1'b0;
        w_is_write   = 1'b0;
        w_misaligned = 1'b0;
        w_be         = 4'b0000;
        w_wdata      = cpu_wdata;
        unique case (cpu_mode)
            MODE_LW: begin
                w_is_read    = 1'b1;
                w_misaligned = (cpu_addr[1:0] != 2'b00);
            end
            MODE_LH, MODE_LHU: begin
                w_is_read    = 1'b1;
                w_misaligned = cpu_addr[0];
            end
            MODE_LB, MODE_LBU: begin
                w_is_read = 1'b1;
            end
            MODE_SW: begin
                w_is_write   = 1'b1;
                w_misaligned = (cpu_addr[1:0] != 2'b00);
                w_be         = 4'b1111;
            end
            MODE_SH: begin
                w_is_write   = 1'b1;
                w_misaligned = cpu_addr[0];
                w_wdata      = {2{cpu_wdata[15:0]}};
                w_be         = cpu_addr[1] ? 4'b1100 : 4'b0011;
            end
            MODE_SB: begin
                w_is_write = 1'b1;
                w_wdata    = {4{cpu_wdata[7:0]}};
                w_be       = 4'b0001 << cpu_addr[1:0];
            end
            default: begin
            end
        endcase
    end

    // Misalignment wins over decode, so a misaligned unmapped access blocks both devices.
    assign w_fault   = (w_is_read || w_is_write) && (w_misaligned || !(w_ram_hit || w_ser_hit));
    assign w_ram_sel = (w_is_read || w_is_write) && !w_misaligned && w_ram_hit;
    assign w_ser_sel = (w_is_read || w_is_write) && !w_misaligned && w_ser_hit;

    assign ram_mode     = w_ram_sel ? (w_is_write ? DEV_WRITE : DEV_READ) : DEV_IDLE;
    assign serial_mode  = w_ser_sel ? (w_is_write ? DEV_WRITE : DEV_READ) : DEV_IDLE;
    assign ram_addr     = cpu_addr[22:2];
    assign serial_addr  = cpu_addr[2];
    assign ram_be       = (w_ram_sel && w_is_write) ? w_be : 4'b0000;
    assign ram_wdata    = w_wdata;
    assign serial_wdata = w_wdata;

    assign w_word = w_ram_sel ? ram_rdata : serial_rdata;
    assign w_lane = w_word >> {cpu_addr[1:0], 3'b000};

    always_comb begin
        w_rdata = 32'h0000_0000;
        if (w_is_read && (w_ram_sel || w_ser_sel)) begin
            unique case (cpu_mode)
                MODE_LW:  w_rdata = w_word;
                MODE_LH:  w_rdata = {{16{w_lane[15]}}, w_lane[15:0]};
                MODE_LHU: w_rdata = {16'h0000, w_lane[15:0]};
                MODE_LB:  w_rdata = {{24{w_lane[7]}}, w_lane[7:0]};
                MODE_LBU: w_rdata = {24'h000000, w_lane[7:0]};
                default:  w_rdata = 32'h0000_0000;
            endcase
        end
    end
    assign cpu_rdata = w_rdata;

    // A new fault beats a same-cycle clear; otherwise the first fault is kept.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_fault       <= 1'b0;
            r_fault_cause <= 2'b00;
            r_fault_addr  <= 32'h0000_0000;
        end else if (w_fault && (!r_fault || fault_clr)) begin
            r_fault       <= 1'b1;
            r_fault_cause <= w_misaligned ? CAUSE_MISALIGNED : CAUSE_UNMAPPED;
            r_fault_addr  <= cpu_addr;
        end else if (fault_clr) begin
            r_fault       <= 1'b0;
            r_fault_cause <= 2'b00;
            r_fault_addr  <= 32'h0000_0000;
        end
    end

    assign fault       = r_fault;
    assign fault_cause = r_fault_cause;
    assign fault_addr  = r_fault_addr;
endmodule

// File: tb/tb_io_manager.sv
// Directed bench for io_manager: combinational decode/lanes and the sticky fault register.
module tb_io_manager;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  cpu_mode;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic [1:0]  ram_mode;
    logic [20:0] ram_addr;
    logic [3:0]  ram_be;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic [1:0]  serial_mode;
    logic        serial_addr;
    logic [31:0] serial_wdata;
    logic [31:0] serial_rdata;
    logic        fault_clr;
    logic        fault;
    logic [1:0]  fault_cause;
    logic [31:0] fault_addr;

    int checks = 0;
    int errors = 0;

    io_manager dut (
        .clk(clk), .rst(rst),
        .cpu_mode(cpu_mode), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .ram_mode(ram_mode), .ram_addr(ram_addr), .ram_be(ram_be), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata),
        .serial_mode(serial_mode), .serial_addr(serial_addr), .serial_wdata(serial_wdata),
        .serial_rdata(serial_rdata),
        .fault_clr(fault_clr), .fault(fault), .fault_cause(fault_cause), .fault_addr(fault_addr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] m, input logic [31:0] a, input logic [31:0] wd);
        @(posedge clk);
        #1;
        cpu_mode  = m;
        cpu_addr  = a;
        cpu_wdata = wd;
        #1;
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; fault_clr = 1'b0;
        cpu_mode = 4'h0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
        ram_rdata = 32'h0; serial_rdata = 32'h0;
        edge_step(); edge_step();
        rst = 1'b1;
        chk("rst_fault", {31'h0, fault}, 32'h0);
        chk("rst_cause", {30'h0, fault_cause}, 32'h0);
        chk("rst_addr", fault_addr, 32'h0);

        // word round trip
        drive(4'b1001, 32'h8000_0010, 32'hDEAD_BEEF);
        chk("sw_ram_mode", {30'h0, ram_mode}, 32'h2);
        chk("sw_ram_addr", {11'h0, ram_addr}, 32'h4);
        chk("sw_ram_be", {28'h0, ram_be}, 32'hF);
        chk("sw_ram_wdata", ram_wdata, 32'hDEAD_BEEF);
        chk("sw_ser_mode", {30'h0, serial_mode}, 32'h0);
        chk("sw_rdata", cpu_rdata, 32'h0);
        ram_rdata = 32'hDEAD_BEEF;
        drive(4'b0001, 32'h8000_0010, 32'h0);
        chk("lw_rdata", cpu_rdata, 32'hDEAD_BEEF);
        chk("lw_ram_mode", {30'h0, ram_mode}, 32'h1);
        chk("lw_ser_mode", {30'h0, serial_mode}, 32'h0);
        chk("lw_ram_be", {28'h0, ram_be}, 32'h0);

        // byte and half lanes
        ram_rdata = 32'h80FF_7F01;
        drive(4'b0100, 32'h8000_0003, 32'h0);
        chk("lb3", cpu_rdata, 32'hFFFF_FF80);
        drive(4'b0101, 32'h8000_0003, 32'h0);
        chk("lbu3", cpu_rdata, 32'h0000_0080);
        drive(4'b0100, 32'h8000_0001, 32'h0);
        chk("lb1", cpu_rdata, 32'h0000_007F);
        drive(4'b0010, 32'h8000_0002, 32'h0);
        chk("lh2", cpu_rdata, 32'hFFFF_80FF);
        drive(4'b0011, 32'h8000_0002, 32'h0);
        chk("lhu2", cpu_rdata, 32'h0000_80FF);
        drive(4'b0010, 32'h8000_0000, 32'h0);
        chk("lh0", cpu_rdata, 32'h0000_7F01);
        drive(4'b1100, 32'h8000_0001, 32'h1234_56AB);
        chk("sb_be", {28'h0, ram_be}, 32'h2);
        chk("sb_wdata", ram_wdata, 32'hABAB_ABAB);
        drive(4'b1010, 32'h8000_0002, 32'h1234_CAFE);
        chk("sh_be", {28'h0, ram_be}, 32'hC);
        chk("sh_wdata", ram_wdata, 32'hCAFE_CAFE);
        drive(4'b0111, 32'h8000_0000, 32'h0);
        chk("idle_code_ram_mode", {30'h0, ram_mode}, 32'h0);
        chk("idle_code_rdata", cpu_rdata, 32'h0);

        // serial
        serial_rdata = 32'h0000_00F5;
        drive(4'b0101, 32'hBFD0_03FC, 32'h0);
        chk("ser_rd_mode", {30'h0, serial_mode}, 32'h1);
        chk("ser_rd_addr", {31'h0, serial_addr}, 32'h1);
        chk("ser_rd_ram_mode", {30'h0, ram_mode}, 32'h0);
        chk("ser_rd_rdata", cpu_rdata, 32'h0000_00F5);
        drive(4'b1100, 32'hBFD0_03F8, 32'h0000_0041);
        chk("ser_wr_mode", {30'h0, serial_mode}, 32'h2);
        chk("ser_wr_addr", {31'h0, serial_addr}, 32'h0);
        chk("ser_wr_data", {24'h0, serial_wdata[7:0]}, 32'h41);
        chk("ser_wr_ram_be", {28'h0, ram_be}, 32'h0);
        edge_step();
        chk("no_fault_yet", {31'h0, fault}, 32'h0);

        // misaligned
        drive(4'b0001, 32'h8000_0002, 32'h0);
        chk("mis_ram_mode", {30'h0, ram_mode}, 32'h0);
        chk("mis_ser_mode", {30'h0, serial_mode}, 32'h0);
        chk("mis_rdata", cpu_rdata, 32'h0);
        edge_step();
        chk("mis_fault", {31'h0, fault}, 32'h1);
        chk("mis_cause", {30'h0, fault_cause}, 32'h2);
        chk("mis_addr", fault_addr, 32'h8000_0002);

        // sticky
        drive(4'b1001, 32'h0000_1000, 32'h1);
        chk("unm_ram_mode", {30'h0, ram_mode}, 32'h0);
        edge_step();
        chk("sticky_addr", fault_addr, 32'h8000_0002);
        chk("sticky_cause", {30'h0, fault_cause}, 32'h2);
        drive(4'b0001, 32'h0000_1000, 32'h0);
        fault_clr = 1'b1;
        edge_step();
        chk("clr_new_fault", {31'h0, fault}, 32'h1);
        chk("clr_new_cause", {30'h0, fault_cause}, 32'h1);
        chk("clr_new_addr", fault_addr, 32'h0000_1000);
        cpu_mode = 4'h0;
        edge_step();
        fault_clr = 1'b0;
        chk("clr_fault", {31'h0, fault}, 32'h0);
        chk("clr_cause", {30'h0, fault_cause}, 32'h0);
        chk("clr_addr", fault_addr, 32'h0);

        // misaligned and unmapped reports misalignment
        drive(4'b1010, 32'h0000_0001, 32'h0);
        edge_step();
        chk("mis_unm_cause", {30'h0, fault_cause}, 32'h2);
        chk("mis_unm_addr", fault_addr, 32'h0000_0001);

        // reset overrides a pending fault; combinational path keeps working
        rst = 1'b0;
        cpu_mode = 4'b0001; cpu_addr = 32'h0000_2000;
        edge_step();
        chk("rst2_fault", {31'h0, fault}, 32'h0);
        chk("rst2_cause", {30'h0, fault_cause}, 32'h0);
        chk("rst2_addr", fault_addr, 32'h0);
        cpu_addr = 32'h8000_0000;
        #1;
        chk("rst2_ram_mode", {30'h0, ram_mode}, 32'h1);
        rst = 1'b1;
        cpu_mode = 4'h0;
        edge_step();
        chk("after_rst_fault", {31'h0, fault}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
